ps2_rx: RTL and testbench
=========================

// Module: ps2_rx
// PURPOSE
//   PS/2 device-to-host serial receiver: synchronises and glitch-filters raw ps2_clk/ps2_data,
//   deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), emits one byte per frame.
//   Sits directly upstream of ps2_keyboard: data_o/valid_o drive its data_i/valid_i unchanged.
// PARAMETERS
//   SYNC_STAGES     2      flops in each pin synchroniser (>=2)
//   FILTER_LEN      8      consecutive equal synced samples required to change filtered ps2_clk
//   TIMEOUT_CYCLES  50000  max clk cycles between filtered falling edges inside a frame (1ms @ 50MHz)
// PORTS
//   clk_i          in   1  system clock
//   rst_ni         in   1  asynchronous active-low reset
//   ps2_clk_i      in   1  raw PS/2 clock pin (async, idle high)
//   ps2_data_i     in   1  raw PS/2 data pin (async, idle high)
//   data_o         out  8  received byte (byte_t), held until next good frame
//   valid_o        out  1  one-cycle pulse: data_o updated with new good byte
//   error_o        out  1  one-cycle pulse: frame discarded (parity/stop/timeout)
//   busy_o         out  1  high while state != IDLE
// BEHAVIOUR
//   Reset (async assert, sync release): sync flops and filtered clk = 1, state IDLE, bit_cnt 0,
//     shift 0, data_o 8'h00, valid_o 0, error_o 0, busy_o 0, timeout counter 0.
//   Filter: counter on synced ps2_clk; filtered value flips only after FILTER_LEN consecutive cycles
//     differing from it; counter clears on any sample equal to filtered value.
//   fall = filtered clk 1->0 (one clk cycle); synced ps2_data sampled that same cycle. Data is not filtered.
//   FSM (advances only on fall, except timeout):
//     IDLE   : data==0 -> DATA, bit_cnt=0; data==1 -> stay IDLE (spurious edge, no error).
//     DATA   : shift = {data, shift[7:1]}; bit_cnt++; after 8th bit (bit_cnt==7) -> PARITY.
//     PARITY : par_ok = ^{shift, data} == 1 (odd); -> STOP.
//     STOP   : data==1 && par_ok -> data_o<=shift, valid_o=1; else error_o=1; -> IDLE either way.
//   Latency: valid_o/error_o high the cycle after the stop-bit fall; raw pin edge to pulse =
//     SYNC_STAGES + FILTER_LEN + 1 cycles.
//   valid_o and error_o never high together; no back-pressure (consumer must accept every pulse).
//   data_o changes only on good frame; bad frame leaves previous byte.
//   Reset mid-frame: partial frame dropped silently, no pulse after release.
//   busy_o = (state != IDLE), registered with state.
//   Host-to-device (inhibit/transmit) unsupported; ps2 pins are inputs only.
// CONFIGURATION
//   PS2_RX_TIMEOUT_EN defined: counter clears on every fall and in IDLE, increments otherwise;
//     at TIMEOUT_CYCLES-1 without fall -> IDLE, error_o pulse, partial byte discarded.
//     Timeout and a fall in the same cycle: the fall wins (counter clears, FSM advances).
//   Not defined: no counter synthesised, TIMEOUT_CYCLES ignored; partial frame waits indefinitely.
// TESTING
//   Frame 0x1C, parity 0, stop 1 -> one valid_o pulse, data_o=8'h1C, error_o stays 0, busy_o low after.
//   Frames 0xF0, 0x1C back-to-back (parity 1, 0) -> two valid pulses, data_o 8'hF0 then 8'h1C.
//   Frame 0x1C with parity 1 -> error_o one pulse, no valid_o, data_o keeps prior value.
//   Frame 0x5A, good parity, stop 0 -> error_o pulse; next good 0x5A frame -> valid_o, data_o=8'h5A.
//   ps2_clk low glitch of FILTER_LEN-1 cycles during IDLE and mid-DATA -> no state/bit_cnt change.
//   TIMEOUT_EN: start + 3 bits then idle TIMEOUT_CYCLES -> error_o pulse, busy_o 0; following 0x29
//     frame -> valid_o, data_o=8'h29. rst_ni low mid-frame -> outputs at reset values, no pulses.

Source files
------------

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host serial receiver.
// Synchronises and glitch-filters the raw PS/2 pins and deserialises 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop). It emits one byte per good frame.
//
// Optional feature macro: PS2_RX_TIMEOUT_EN
//   When defined, a frame is abandoned if TIMEOUT_CYCLES clk cycles pass between filtered
//   falling edges. When undefined, no counter is built and TIMEOUT_CYCLES is only range-checked.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   ps2_clk_i   raw PS/2 clock pin (async, idle high)
//   ps2_data_i  raw PS/2 data pin (async, idle high)
//   data_o      last good received byte, held until the next good frame
//   valid_o     one-cycle pulse: data_o updated
//   error_o     one-cycle pulse: frame discarded (parity/stop/timeout)
//   busy_o      high while a frame is in progress
module ps2_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       error_o,
  output logic       busy_o
);

  localparam int unsigned FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Parameter range checks at elaboration.
  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ps2_rx: SYNC_STAGES>=2, FILTER_LEN>=1 and TIMEOUT_CYCLES>=2 are required");
  end

  // Pin synchronisers; both reset to the idle-high level.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_i};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Glitch filter: flip only after FILTER_LEN consecutive samples that disagree.
  logic           filt;
  logic           filt_q;
  logic [FCW-1:0] filt_cnt;
  logic           fall_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt     <= 1'b1;
      filt_q   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_q <= filt;
      if (clk_s == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt     <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end
  end

  assign fall_c = filt_q & ~filt;

  // Frame FSM state and registered outputs.
  state_t     state;
  state_t     state_d;
  byte_t      shift;
  byte_t      shift_d;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_d;
  logic       par_ok;
  logic       par_ok_d;
  byte_t      data_d;
  logic       valid_d;
  logic       error_d;
  logic       timeout_c;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES);

  logic [TOW-1:0] to_cnt;

  // Inter-edge watchdog, idle outside a frame; a fall in the expiry cycle takes priority.
  assign timeout_c = (state != IDLE) && !fall_c && (to_cnt == TOW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt <= '0;
    end else if (fall_c || state == IDLE || timeout_c) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TOW'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      par_ok  <= 1'b0;
      data_o  <= 8'h00;
      valid_o <= 1'b0;
      error_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_cnt <= bit_cnt_d;
      par_ok  <= par_ok_d;
      data_o  <= data_d;
      valid_o <= valid_d;
      error_o <= error_d;
      busy_o  <= (state_d != IDLE);
    end
  end

  // Next-state: advances on a filtered falling edge, or aborts on timeout.
  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    par_ok_d  = par_ok;
    data_d    = data_o;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    if (fall_c) begin
      unique case (state)
        IDLE: begin
          // A high data bit here is a spurious edge, not a start bit.
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {data_s, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_ok_d = ^{shift, data_s};
          state_d  = STOP;
        end
        STOP: begin
          if (data_s && par_ok) begin
            data_d  = shift;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_c) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      error_d   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed self-checking bench for ps2_rx.
// Drives PS/2 frames bit by bit on the raw pins, counts valid/error pulses in a monitor
// and checks outputs against hand-computed values.
module tb_ps2_rx;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILTER_LEN  = 8;
  localparam int unsigned TO_CYCLES   = 300;
  localparam int unsigned HALF        = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       error;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;
  int ecnt    = 0;
  int both    = 0;
  logic [7:0] vq[$];

  always #5 clk = ~clk;

  ps2_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .data_o    (data),
    .valid_o   (valid),
    .error_o   (error),
    .busy_o    (busy)
  );

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      vq.push_back(data);
    end
    if (error) ecnt++;
    if (valid && error) both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic glitch();
    @(negedge clk) ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Full frame; glitch_at >= 0 injects a short clk glitch after that many bits.
  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop,
                            input int glitch_at);
    logic [10:0] bits;
    bits = {stop, (~^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == glitch_at) begin
        glitch();
        check("glitch_mid_busy", 32'(busy), 32'd1);
      end
      send_bit(bits[i]);
    end
    @(negedge clk) ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Start bit plus the first nbits data bits, then the line goes idle.
  task automatic send_partial(input logic [7:0] d, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    @(negedge clk) ps2_data = 1'b1;
  endtask

  int v0;
  int e0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single good frame.
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("good_valid_cnt", 32'(vcnt - v0), 32'd1);
    check("good_error_cnt", 32'(ecnt - e0), 32'd0);
    check("good_data", 32'(data), 32'h1C);
    check("good_busy_after", 32'(busy), 32'd0);

    // Back-to-back frames.
    v0 = vcnt;
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("b2b_valid_cnt", 32'(vcnt - v0), 32'd2);
    if (vq.size() >= 2) begin
      check("b2b_first", 32'(vq[vq.size()-2]), 32'hF0);
      check("b2b_second", 32'(vq[vq.size()-1]), 32'h1C);
    end else begin
      check("b2b_queue_size", 32'(vq.size()), 32'd2);
    end

    // Bad parity.
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    check("par_error_cnt", 32'(ecnt - e0), 32'd1);
    check("par_valid_cnt", 32'(vcnt - v0), 32'd0);
    check("par_data_kept", 32'(data), 32'h1C);

    // Bad stop bit, then a good frame of the same byte.
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h5A, 1'b0, 1'b0, -1);
    check("stop_error_cnt", 32'(ecnt - e0), 32'd1);
    check("stop_valid_cnt", 32'(vcnt - v0), 32'd0);
    check("stop_data_kept", 32'(data), 32'h1C);
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    check("stop_recover_valid", 32'(vcnt - v0), 32'd1);
    check("stop_recover_data", 32'(data), 32'h5A);

    // Short glitches: in IDLE and mid-data.
    v0 = vcnt; e0 = ecnt;
    glitch();
    check("glitch_idle_busy", 32'(busy), 32'd0);
    check("glitch_idle_pulses", 32'(vcnt - v0 + ecnt - e0), 32'd0);
    send_frame(8'h33, 1'b0, 1'b1, 4);
    check("glitch_mid_valid", 32'(vcnt - v0), 32'd1);
    check("glitch_mid_error", 32'(ecnt - e0), 32'd0);
    check("glitch_mid_data", 32'(data), 32'h33);

`ifdef PS2_RX_TIMEOUT_EN
    // Abandoned frame times out.
    v0 = vcnt; e0 = ecnt;
    send_partial(8'hA5, 3);
    check("to_busy_during", 32'(busy), 32'd1);
    repeat (TO_CYCLES + 50) @(negedge clk);
    check("to_error_cnt", 32'(ecnt - e0), 32'd1);
    check("to_valid_cnt", 32'(vcnt - v0), 32'd0);
    check("to_busy_after", 32'(busy), 32'd0);
    send_frame(8'h29, 1'b0, 1'b1, -1);
    check("to_next_valid", 32'(vcnt - v0), 32'd1);
    check("to_next_data", 32'(data), 32'h29);
`endif

    // Reset in the middle of a frame.
    send_partial(8'hC3, 4);
    @(negedge clk) rst_n = 1'b0;
    v0 = vcnt; e0 = ecnt;
    repeat (3) @(negedge clk);
    check("mrst_data", 32'(data), 32'h00);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_error", 32'(error), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2 * TO_CYCLES) @(negedge clk);
    check("mrst_no_pulses", 32'(vcnt - v0 + ecnt - e0), 32'd0);
    check("mrst_busy_after", 32'(busy), 32'd0);
    send_frame(8'h29, 1'b0, 1'b1, -1);
    check("mrst_next_valid", 32'(vcnt - v0), 32'd1);
    check("mrst_next_data", 32'(data), 32'h29);

    check("valid_error_exclusive", 32'(both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
